// File: rtl/i2s_tx_stream.sv
// i2s_tx_stream: parametrised I2S / left-justified stereo serializer for the audio DAC Pmod.
// All serial timing is derived from clk with internal dividers (no derived clocks).
// Sample pairs enter through a valid/ready handshake into a one-frame holding register.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   en                  serializer enable; low holds sck/lrck/sdata at 0
//   s_left, s_right     sample pair (two's complement, SAMPLE_W bits)
//   s_valid, s_ready    input handshake; s_ready = holding register empty
//   audio_mclk          free-running master clock (clk / (2*MCLK_HALF))
//   audio_sck           bit clock (clk / (2*SCK_HALF)) while running
//   audio_lrck          word select, 0 = left
//   audio_sdata         serial data, MSB first, changes on sck falling edges
//   frame_start         one-clk pulse when a frame is loaded
//   underrun            one-clk pulse with frame_start when no sample was held
//   underrun_cnt        saturating underrun counter (only with I2S_TX_UNDERRUN_CNT_EN)
//
// Optional feature macro: I2S_TX_UNDERRUN_CNT_EN

module i2s_tx_stream #(
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned SLOT_W    = 16,
    parameter int unsigned SCK_HALF  = 8,
    parameter int unsigned MCLK_HALF = 2,
    parameter int unsigned MODE      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                audio_mclk,
    output logic                audio_sck,
    output logic                audio_lrck,
    output logic                audio_sdata,
    output logic                frame_start,
    output logic                underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);

    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned DIV_W   = $clog2(SCK_HALF);
    localparam int unsigned MCLK_W  = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int unsigned PAD_W   = SLOT_W - SAMPLE_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [MCLK_W-1:0]    r_mclk_cnt;
    logic                 r_mclk;
    logic [DIV_W-1:0]     r_div;
    logic                 r_sck;
    logic [BIT_W-1:0]     r_bit_idx;
    logic                 r_lrck;
    logic [FRAME_W-1:0]   r_shift;
    logic [SAMPLE_W-1:0]  r_hold_l;
    logic [SAMPLE_W-1:0]  r_hold_r;
    logic                 r_hold_empty;
    logic                 r_frame_start;
    logic                 r_underrun;

    logic [DIV_W-1:0]     w_div_nxt;
    logic                 w_sck_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [BIT_W-1:0]     w_bit_p1;
    logic                 w_lrck_nxt;
    logic [FRAME_W-1:0]   w_shift_nxt;
    logic [SAMPLE_W-1:0]  w_hold_l_nxt;
    logic [SAMPLE_W-1:0]  w_hold_r_nxt;
    logic                 w_hold_empty_nxt;
    logic                 w_fs_nxt;
    logic                 w_ur_nxt;
    logic                 w_load;
    logic                 w_sck_wrap;
    logic                 w_sck_fall;
    logic                 w_last_bit;
    logic                 w_accept;
    logic [SLOT_W-1:0]    w_slot_l;
    logic [SLOT_W-1:0]    w_slot_r;

    assign w_sck_wrap = (r_div == DIV_W'(SCK_HALF - 1));
    assign w_sck_fall = w_sck_wrap & r_sck;
    assign w_last_bit = (r_bit_idx == BIT_W'(FRAME_W - 1));
    assign w_accept   = s_valid & r_hold_empty;
    // Samples are left-aligned in their slot; low bits are zero padding.
    assign w_slot_l   = SLOT_W'(r_hold_l) << PAD_W;
    assign w_slot_r   = SLOT_W'(r_hold_r) << PAD_W;

    // Master clock: free-running divider, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mclk_cnt <= '0;
            r_mclk     <= 1'b0;
        end else if (r_mclk_cnt == MCLK_W'(MCLK_HALF - 1)) begin
            r_mclk_cnt <= '0;
            r_mclk     <= ~r_mclk;
        end else begin
            r_mclk_cnt <= r_mclk_cnt + MCLK_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, divider, shifter and holding-register logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_div_nxt        = r_div;
        w_sck_nxt        = r_sck;
        w_bit_nxt        = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_hold_l_nxt     = r_hold_l;
        w_hold_r_nxt     = r_hold_r;
        w_hold_empty_nxt = r_hold_empty;
        w_fs_nxt         = 1'b0;
        w_ur_nxt         = 1'b0;
        w_load           = 1'b0;
        w_lrck_nxt       = 1'b0;
        w_bit_p1         = '0;

        case (r_state)
            ST_IDLE: begin
                w_div_nxt   = '0;
                w_sck_nxt   = 1'b0;
                w_bit_nxt   = '0;
                w_shift_nxt = '0;
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // Abort immediately; partial frame dropped, holding kept.
                    w_state_nxt = ST_IDLE;
                    w_div_nxt   = '0;
                    w_sck_nxt   = 1'b0;
                    w_bit_nxt   = '0;
                    w_shift_nxt = '0;
                end else begin
                    if (w_sck_wrap) begin
                        w_div_nxt = '0;
                        w_sck_nxt = ~r_sck;
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                    if (w_sck_fall) begin
                        if (w_last_bit) begin
                            w_bit_nxt = '0;
                            w_load    = 1'b1;
                        end else begin
                            w_bit_nxt   = r_bit_idx + BIT_W'(1);
                            w_shift_nxt = r_shift << 1;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Frame load: held pair if available, otherwise silence plus underrun.
        if (w_load) begin
            w_fs_nxt = 1'b1;
            if (!r_hold_empty) begin
                w_shift_nxt      = {w_slot_l, w_slot_r};
                w_hold_empty_nxt = 1'b1;
            end else begin
                w_shift_nxt = '0;
                w_ur_nxt    = 1'b1;
            end
        end

        // Accept only into an empty holding register; never bypassed into the shifter.
        if (w_accept) begin
            w_hold_l_nxt     = s_left;
            w_hold_r_nxt     = s_right;
            w_hold_empty_nxt = 1'b0;
        end

        // I2S mode leads LRCK by one bit so it flips one SCK before each slot MSB.
        w_bit_p1 = (w_bit_nxt == BIT_W'(FRAME_W - 1)) ? '0 : w_bit_nxt + BIT_W'(1);
        if (w_state_nxt == ST_RUN) begin
            if (MODE == 1) begin
                w_lrck_nxt = (w_bit_nxt >= BIT_W'(SLOT_W));
            end else begin
                w_lrck_nxt = (w_bit_p1 >= BIT_W'(SLOT_W));
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_sck         <= 1'b0;
            r_bit_idx     <= '0;
            r_lrck        <= 1'b0;
            r_shift       <= '0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_hold_empty  <= 1'b1;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_sck         <= w_sck_nxt;
            r_bit_idx     <= w_bit_nxt;
            r_lrck        <= w_lrck_nxt;
            r_shift       <= w_shift_nxt;
            r_hold_l      <= w_hold_l_nxt;
            r_hold_r      <= w_hold_r_nxt;
            r_hold_empty  <= w_hold_empty_nxt;
            r_frame_start <= w_fs_nxt;
            r_underrun    <= w_ur_nxt;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    // Saturating underrun counter, updated on the same edge as the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun_cnt <= '0;
        end else if (w_ur_nxt && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

    assign s_ready     = r_hold_empty;
    assign audio_mclk  = r_mclk;
    assign audio_sck   = r_sck;
    assign audio_lrck  = r_lrck;
    assign audio_sdata = r_shift[FRAME_W-1];
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: doc/i2s_tx_stream.md
Name: i2s_tx_stream

Overview:
- Parametrised I2S/left-justified stereo serializer driving the audio DAC Pmod; successor to the fixed 16-bit, 32-clocks-per-frame serializer.
- All timing is generated from the single system clock `clk` with internal counters. There are no derived clocks inside the block.
- Samples enter through a valid/ready handshake into a one-frame holding register, so the upstream source does not need to track LRCK.
- Adds selectable I2S or left-justified framing, zero-padding of short samples, an enable control and underrun detection.

Parameters:
- SAMPLE_W, 16: bits per channel sample; must be ≤ SLOT_W.
- SLOT_W, 16: SCK periods per channel slot; one frame = 2*SLOT_W SCK periods.
- SCK_HALF, 8: clk cycles per SCK half-period; must be ≥ 2.
- MCLK_HALF, 2: clk cycles per MCLK half-period; must be ≥ 1.
- MODE, 0: 0 = I2S (one-SCK delay after LRCK edge), 1 = left-justified.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  serializer enable; low holds the serial outputs idle
- s_left  input  SAMPLE_W  left sample, two's complement
- s_right  input  SAMPLE_W  right sample
- s_valid  input  1  sample pair valid
- s_ready  output  1  holding register empty
- audio_mclk  output  1  master clock
- audio_sck  output  1  bit clock
- audio_lrck  output  1  word select; 0 = left
- audio_sdata  output  1  serial data, MSB first
- frame_start  output  1  one-clk pulse when a frame is loaded
- underrun  output  1  one-clk pulse coincident with frame_start when no sample was available

Behaviour:
- Reset values: all outputs 0 except s_ready = 1. All counters are 0, holding and shift registers are 0, and the FSM is in IDLE.
- MCLK:
  - Free-running whenever rst_n is high, independent of en.
  - Toggles when its counter reaches MCLK_HALF-1, then the counter wraps to 0.
- FSM states: IDLE and RUN.
- IDLE:
  - audio_sck, audio_lrck and audio_sdata are held at 0; the SCK divider and bit index are held at 0.
  - IDLE -> RUN when en = 1. On that clk edge the shift register loads a frame (load rules below) and frame_start pulses.
- RUN:
  - The divider counts 0..SCK_HALF-1. audio_sck toggles on wrap, so SCK period = 2*SCK_HALF clk cycles.
  - The first SCK rising edge occurs SCK_HALF clks after entering RUN.
  - On each SCK falling transition (the clk edge at which sck goes 1->0), the shift register shifts left one bit and bit_idx increments modulo 2*SLOT_W.
  - When bit_idx wraps from 2*SLOT_W-1 to 0, a new frame loads instead of shifting, and frame_start pulses.
- RUN -> IDLE:
  - Occurs at the clk edge where en = 0 is sampled, immediately, including mid-frame.
  - The partial frame is discarded; the holding register is preserved.
- Frame layout:
  - Shift register width is 2*SLOT_W.
  - Loaded as {left, zeros(SLOT_W-SAMPLE_W), right, zeros(SLOT_W-SAMPLE_W)}.
  - audio_sdata = shift register MSB. Data changes only on SCK falling edges; the DAC samples on rising edges.
- LRCK:
  - MODE=1: audio_lrck = (bit_idx ≥ SLOT_W).
  - MODE=0: audio_lrck = (((bit_idx+1) mod 2*SLOT_W) ≥ SLOT_W). LRCK therefore changes one SCK before each slot's MSB.
  - In MODE=0, the first frame after leaving IDLE starts with LRCK already low.
- Holding register and handshake:
  - s_ready is the inverse of the holding-full flag.
  - A sample pair is accepted on a clk edge with s_valid & s_ready; s_valid is ignored while s_ready = 0.
  - At a frame load with holding full: the held pair is loaded, holding empties, and s_ready = 1 from the next clk.
  - At a frame load with holding empty: all-zero data is loaded and underrun pulses.
  - A pair accepted on the same edge as an empty-holding load is not bypassed. It is stored for the next frame, and underrun still pulses.
- Reset mid-operation: asynchronous return to the reset values, including discarding the holding register.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt [15:0], reset to 0.
  - Increments on each underrun pulse and saturates at 16'hFFFF.
  - Cleared only by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then en=0 for 100 clks -> sck/lrck/sdata stay 0, s_ready = 1, mclk toggles every 2 clks.
2. Defaults, MODE=1: preload L=16'hA5A5, R=16'h1234, raise en -> frame_start once; the 32 sdata bits sampled on sck rising edges are A5A5 then 1234, MSB first; lrck low for the first 16 bits and high for the next 16; sck period = 16 clks.
3. Same data, MODE=0 -> lrck rises at bit_idx 15 and falls at bit_idx 31; sdata unchanged relative to bit_idx; frame period = 512 clks.
4. No sample supplied for the second frame -> underrun pulses with frame_start; 32 zero bits are sent; with the macro defined, underrun_cnt = 1.
5. SAMPLE_W=12, SLOT_W=16: L=12'hFFF, R=12'h801 -> slots carry FFF0 and 8010.
6. Drop en at bit_idx 10 with holding full -> next clk sck/lrck/sdata = 0 and s_ready stays 0; re-raise en -> the held pair is sent from bit 0.
